// File: rtl/fir_coef_loader.sv
// Double-buffered coefficient loader for the pipelined FIR: streams a full tap set
// into the shadow bank and swaps it in atomically on a sample-aligned tick.
module fir_coef_loader #(
    parameter int TAPS       = 100,
    parameter int COEF_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [COEF_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  swap_tick,
    output logic [COEF_WIDTH-1:0] coef [0:TAPS-1],
    output logic                  swap_done,
    output logic                  err_len,
    output logic                  busy
);

    localparam int CNT_WIDTH = $clog2(TAPS);
    localparam logic [CNT_WIDTH-1:0]  LAST_IDX = CNT_WIDTH'(TAPS - 1);
    localparam logic [COEF_WIDTH-1:0] UNITY    = {1'b0, {(COEF_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, LOAD, DISCARD, PEND} state_t;

    state_t                 state, state_next;
    logic [CNT_WIDTH-1:0]   cnt, cnt_next;
    logic [CNT_WIDTH-1:0]   wr_idx;
    logic                   sel, sel_next;
    logic                   err_next, swap_next, wr_en, xfer;
    logic [COEF_WIDTH-1:0]  bank [0:1][0:TAPS-1];

    assign xfer = s_valid && s_ready;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        sel_next   = sel;
        err_next   = 1'b0;
        swap_next  = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = cnt;
        s_ready    = (state != PEND);
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (xfer) begin
                    wr_en  = 1'b1;
                    wr_idx = '0;
                    if (s_last) begin
                        err_next = 1'b1;
                        cnt_next = '0;
                    end else begin
                        cnt_next   = CNT_WIDTH'(1);
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (s_last) begin
                        if (cnt == LAST_IDX) begin
                            state_next = PEND;
                        end else begin
                            err_next   = 1'b1;
                            cnt_next   = '0;
                            state_next = IDLE;
                        end
                    end else if (cnt == LAST_IDX) begin
                        state_next = DISCARD;
                    end else begin
                        cnt_next = cnt + CNT_WIDTH'(1);
                    end
                end
            end
            DISCARD: begin
                // Overlong set: swallow the tail until s_last, counter frozen.
                if (xfer && s_last) begin
                    err_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            PEND: begin
                if (swap_tick) begin
                    sel_next   = !sel;
                    swap_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sel       <= 1'b0;
            swap_done <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            sel       <= sel_next;
            swap_done <= swap_next;
            err_len   <= err_next;
        end
    end

    // Only the shadow bank is ever written; the active one stays frozen until the swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < TAPS; i++) begin
                    bank[b][i] <= (i == 0) ? UNITY : '0;
                end
            end
        end else if (wr_en) begin
            bank[!sel][wr_idx] <= s_data;
        end
    end

    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            coef[i] = bank[sel][i];
        end
    end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Self-checking bench for fir_coef_loader: a queue-based reference model of tap sets
// plus constant vector tables and directed multi-cycle sequences.
module tb_fir_coef_loader;

    localparam int TAPS = 100;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [CW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          swap_tick = 1'b0;
    logic [CW-1:0] coef [0:TAPS-1];
    logic          swap_done, err_len, busy;

    int checks = 0;
    int errors = 0;

    fir_coef_loader #(.TAPS(TAPS), .COEF_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .swap_tick(swap_tick), .coef(coef), .swap_done(swap_done),
        .err_len(err_len), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: a set is the list of accepted words; it becomes active only
    // when it is exactly TAPS long and a later tick arrives.
    logic [CW-1:0] m_q [$];
    logic [CW-1:0] m_active [TAPS];
    logic [CW-1:0] m_pend [TAPS];
    logic          m_pending = 1'b0;
    logic          m_overflow = 1'b0;
    logic          m_sel = 1'b0;
    logic          e_err = 1'b0;
    logic          e_swap = 1'b0;

    task automatic modelStep(input logic v, input logic [CW-1:0] d, input logic l,
                             input logic t, input logic r);
        if (r) begin
            m_q.delete();
            m_pending  = 1'b0;
            m_overflow = 1'b0;
            m_sel      = 1'b0;
            e_err      = 1'b0;
            e_swap     = 1'b0;
            for (int i = 0; i < TAPS; i++) m_active[i] = (i == 0) ? 16'h7FFF : 16'h0000;
        end else begin
            e_err  = 1'b0;
            e_swap = 1'b0;
            if (m_pending) begin
                if (t) begin
                    m_active  = m_pend;
                    m_pending = 1'b0;
                    e_swap    = 1'b1;
                    m_sel     = !m_sel;
                end
            end else if (v) begin
                if (m_overflow) begin
                    if (l) begin
                        e_err      = 1'b1;
                        m_overflow = 1'b0;
                    end
                end else begin
                    m_q.push_back(d);
                    if (l) begin
                        if (m_q.size() == TAPS) begin
                            for (int i = 0; i < TAPS; i++) m_pend[i] = m_q[i];
                            m_pending = 1'b1;
                        end else begin
                            e_err = 1'b1;
                        end
                        m_q.delete();
                    end else if (m_q.size() == TAPS) begin
                        m_overflow = 1'b1;
                        m_q.delete();
                    end
                end
            end
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        int bad;
        bad = -1;
        checkBit("s_ready", s_ready, !m_pending);
        checkBit("busy", busy, m_pending || m_overflow || (m_q.size() != 0));
        checkBit("swap_done", swap_done, e_swap);
        checkBit("err_len", err_len, e_err);
        checks++;
        for (int i = 0; i < TAPS; i++) begin
            if (bad < 0 && coef[i] !== m_active[i]) bad = i;
        end
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL coef[%0d] actual=%h expected=%h at %0t",
                     bad, coef[bad], m_active[bad], $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [CW-1:0] d, input logic l,
                                 input logic t, input logic r);
        @(negedge clk);
        s_valid   = v;
        s_data    = d;
        s_last    = l;
        swap_tick = t;
        rst       = r;
        @(posedge clk);
        modelStep(v, d, l, t, r);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n, input logic t);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'($urandom), 1'b0, t, 1'b0);
    endtask

    // Full set of TAPS words, value = base + step*k; optional gaps and tick on last word.
    task automatic loadSet(input int base, input int step, input logic gaps, input logic tick_on_last);
        for (int k = 0; k < TAPS; k++) begin
            if (gaps) applyStimulus(1'b0, 16'($urandom), 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b1, 16'(base + step * k), k == TAPS - 1,
                          (k == TAPS - 1) && tick_on_last, 1'b0);
        end
    endtask

    typedef struct {
        logic          v;
        logic [CW-1:0] d;
        logic          l;
        logic          t;
        logic          r;
        logic          e_ready;
        logic          e_busy;
        logic          e_swap;
        logic          e_err;
    } vec_t;

    vec_t tbl [8];
    logic [CW-1:0] set_a [TAPS];
    logic [CW-1:0] set_b [TAPS];

    initial begin
        tbl[0] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 16'h0006, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset, then idle: unity impulse, ready, no pulses.
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        idle(5, 1'b0);
        checkBit("reset coef0", coef[0] == 16'h7FFF, 1'b1);
        checkBit("reset coef99", coef[99] == 16'h0000, 1'b1);

        // Constant vector table: short sets and stray ticks outside PEND.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].t, tbl[i].r);
            checkBit($sformatf("tbl%0d ready", i), s_ready, tbl[i].e_ready);
            checkBit($sformatf("tbl%0d busy", i), busy, tbl[i].e_busy);
            checkBit($sformatf("tbl%0d swap", i), swap_done, tbl[i].e_swap);
            checkBit($sformatf("tbl%0d err", i), err_len, tbl[i].e_err);
        end

        // Full load k+1, held in PEND until tick.
        loadSet(1, 1, 1'b0, 1'b0);
        idle(3, 1'b0);
        checkBit("pend ready", s_ready, 1'b0);
        checkBit("pend coef0 unchanged", coef[0] == 16'h7FFF, 1'b1);
        idle(1, 1'b1);
        checkBit("swap coef99", coef[99] == 16'd100, 1'b1);
        checkBit("swap_done pulse", swap_done, 1'b1);
        idle(1, 1'b0);
        checkBit("swap_done one cycle", swap_done, 1'b0);

        // Gappy load, tick on the last word is ignored.
        loadSet(1, 1, 1'b1, 1'b1);
        checkBit("tick with last ignored", swap_done, 1'b0);
        idle(1, 1'b0);
        checkBit("no swap after last", swap_done, 1'b0);
        idle(1, 1'b1);
        checkBit("gappy swap coef50", coef[50] == 16'd51, 1'b1);

        // Short set (50 words) then overlong set (105 words).
        for (int k = 0; k < 50; k++) applyStimulus(1'b1, 16'h4000, k == 49, 1'b0, 1'b0);
        checkBit("short err", err_len, 1'b1);
        idle(1, 1'b0);
        for (int k = 0; k < 105; k++) applyStimulus(1'b1, 16'h5000, k == 104, 1'b1, 1'b0);
        checkBit("long err", err_len, 1'b1);
        checkBit("long coef0 kept", coef[0] == 16'd1, 1'b1);
        idle(2, 1'b1);

        // Reset mid-load, then full load of -(k+1).
        for (int k = 0; k < 40; k++) applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        checkBit("rst impulse", coef[0] == 16'h7FFF && coef[1] == 16'h0000, 1'b1);
        loadSet(-1, -1, 1'b0, 1'b0);
        idle(1, 1'b1);
        checkBit("neg coef0", coef[0] == 16'hFFFF, 1'b1);
        checkBit("neg sel", dut.sel, m_sel);

        // Back-to-back sets A and B; B starts in the swap_done cycle.
        for (int k = 0; k < TAPS; k++) begin
            set_a[k] = 16'($urandom);
            set_b[k] = 16'($urandom);
        end
        for (int k = 0; k < TAPS; k++) applyStimulus(1'b1, set_a[k], k == TAPS - 1, 1'b0, 1'b0);
        idle(1, 1'b1);
        checkBit("A sel", dut.sel, m_sel);
        checkBit("A coef", coef[TAPS-1] == set_a[TAPS-1], 1'b1);
        for (int k = 0; k < TAPS; k++) applyStimulus(1'b1, set_b[k], k == TAPS - 1, 1'b0, 1'b0);
        idle(1, 1'b1);
        checkBit("B sel", dut.sel, m_sel);
        checkBit("B coef", coef[0] == set_b[0], 1'b1);

        // Randomized sets of varying length, gaps and ticks.
        for (int s = 0; s < 12; s++) begin
            int target;
            int sent;
            case ($urandom_range(0, 3))
                0, 1:    target = TAPS;
                2:       target = $urandom_range(1, TAPS - 1);
                default: target = $urandom_range(TAPS + 1, TAPS + 8);
            endcase
            sent = 0;
            while (sent < target) begin
                logic v;
                v = ($urandom_range(0, 2) != 0);
                applyStimulus(v, 16'($urandom), v && (sent == target - 1),
                              $urandom_range(0, 3) == 0, 1'b0);
                if (v) sent++;
            end
            for (int c = 0; c < 30 && m_pending; c++) idle(1, $urandom_range(0, 2) == 0);
            if (m_pending) idle(1, 1'b1);
        end
        idle(2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
